// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared fetch-stage types and constants
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] PC_RESET  = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction-memory request/ack handshake
interface if_fetch_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - single-entry PC/instruction buffer used while IF/ID is stalled
module if_skid_buf
    import cpu_pipe_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF stage: PC, imem handshake, IF/ID register; IF_FETCH_PERF_EN adds stall/flush counters
module if_fetch_ctrl
    import cpu_pipe_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   PCWrite_i,
    input  logic                   IFIDStall_i,
    input  logic                   IFFlush_i,
    input  logic                   PCSrc_i,
    input  logic [31:0]            BranchTarget_i,
    if_fetch_ctrl_if.master        imem,
    output logic [31:0]            IFID_PC_o,
    output logic [31:0]            IFID_Instr_o,
    output logic                   IFID_Valid_o,
    output logic                   FetchBusy_o,
    output logic [31:0]            StallCnt_o,
    output logic [31:0]            FlushCnt_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, redir_q, redir_d;
    logic         squash_q, squash_d;
    logic [31:0]  pc_inc, pc_adv;
    logic         kill;
    logic         ifid_ld, ifid_valid_d;
    logic [31:0]  ifid_pc_d, ifid_instr_d;
    logic         buf_load, buf_clear, buf_valid;
    logic [31:0]  buf_pc, buf_instr;

    assign pc_inc      = pc_q + PC_STEP;
    assign pc_adv      = PCWrite_i ? pc_inc : pc_q;
    assign kill        = PCSrc_i | IFFlush_i;
    assign imem.req    = (state_q == REQ);
    assign imem.addr   = pc_q;
    assign FetchBusy_o = (state_q == REQ) & ~imem.ack;

    if_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (buf_load),
        .clear    (buf_clear),
        .pc_in    (pc_inc),
        .instr_in (imem.data),
        .valid    (buf_valid),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            pc_q     <= PC_RESET;
            redir_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            redir_q  <= redir_d;
            squash_q <= squash_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        squash_d     = squash_q;
        ifid_ld      = 1'b0;
        ifid_pc_d    = '0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                ifid_ld = kill;
            end
            REQ: begin
                if (imem.ack) begin
                    if (PCSrc_i) begin
                        pc_d     = BranchTarget_i;
                        squash_d = 1'b0;
                        ifid_ld  = 1'b1;
                    end else if (squash_q) begin
                        // returning word belongs to the abandoned path
                        pc_d     = redir_q;
                        squash_d = 1'b0;
                        ifid_ld  = kill | ~IFIDStall_i;
                    end else if (IFFlush_i) begin
                        pc_d    = pc_adv;
                        ifid_ld = 1'b1;
                    end else if (IFIDStall_i) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        ifid_ld      = 1'b1;
                        ifid_pc_d    = pc_inc;
                        ifid_instr_d = imem.data;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_adv;
                    end
                end else begin
                    // address must stay put until ack, so defer the redirect
                    if (PCSrc_i) begin
                        redir_d  = BranchTarget_i;
                        squash_d = 1'b1;
                    end
                    ifid_ld = kill | ~IFIDStall_i;
                end
            end
            HOLD: begin
                if (kill) begin
                    buf_clear = 1'b1;
                    ifid_ld   = 1'b1;
                    pc_d      = PCSrc_i ? BranchTarget_i : pc_adv;
                    state_d   = REQ;
                end else if (!IFIDStall_i) begin
                    buf_clear    = 1'b1;
                    ifid_ld      = 1'b1;
                    ifid_pc_d    = buf_pc;
                    ifid_instr_d = buf_instr;
                    ifid_valid_d = buf_valid;
                    pc_d         = pc_adv;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            IFID_PC_o    <= '0;
            IFID_Instr_o <= NOP_INSTR;
            IFID_Valid_o <= 1'b0;
        end else if (ifid_ld) begin
            IFID_PC_o    <= ifid_pc_d;
            IFID_Instr_o <= ifid_instr_d;
            IFID_Valid_o <= ifid_valid_d;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (IFIDStall_i && state_q != IDLE && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (PCSrc_i && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCnt_o = stall_cnt_q;
    assign FlushCnt_o = flush_cnt_q;
`else
    assign StallCnt_o = '0;
    assign FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed and randomized checks of if_fetch_ctrl against a fetch model
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        PCWrite_i, IFIDStall_i, IFFlush_i, PCSrc_i;
    logic [31:0] BranchTarget_i;
    logic [31:0] IFID_PC_o, IFID_Instr_o, StallCnt_o, FlushCnt_o;
    logic        IFID_Valid_o, FetchBusy_o;

    if_fetch_ctrl_if imem ();

    if_fetch_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .PCWrite_i      (PCWrite_i),
        .IFIDStall_i    (IFIDStall_i),
        .IFFlush_i      (IFFlush_i),
        .PCSrc_i        (PCSrc_i),
        .BranchTarget_i (BranchTarget_i),
        .imem           (imem.master),
        .IFID_PC_o      (IFID_PC_o),
        .IFID_Instr_o   (IFID_Instr_o),
        .IFID_Valid_o   (IFID_Valid_o),
        .FetchBusy_o    (FetchBusy_o),
        .StallCnt_o     (StallCnt_o),
        .FlushCnt_o     (FlushCnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: the fetcher is either waiting on memory, or parked on one
    // buffered word; a pending branch is remembered until memory answers.
    bit          m_started, m_hold, m_pend;
    logic [31:0] m_pc, m_pend_tgt, m_buf_word;
    logic [31:0] m_ifpc, m_ifinstr;
    bit          m_ifvalid;
    logic [31:0] m_stall_cnt, m_flush_cnt;

    int  mem_wait, mem_lat;
    bit  rand_lat;
    bit  last_busy;

    function automatic bit m_req();
        return m_started && !m_hold;
    endfunction

    task automatic m_bubble();
        m_ifpc = 0; m_ifinstr = 0; m_ifvalid = 0;
    endtask

    task automatic m_reset();
        m_started = 0; m_hold = 0; m_pend = 0;
        m_pc = 0; m_pend_tgt = 0; m_buf_word = 0;
        m_bubble();
        m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic model_step(input bit ack, input logic [31:0] word, input bit st, input bit pw,
                              input bit src, input bit fl, input logic [31:0] tgt);
        logic [31:0] nxt;
        nxt = pw ? m_pc + 4 : m_pc;
        if (src && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        if (st && m_started && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        if (!m_started) begin
            m_started = 1;
            return;
        end
        if (m_hold) begin
            if (src || fl) begin
                m_bubble(); m_hold = 0; m_pc = src ? tgt : nxt;
            end else if (!st) begin
                m_ifpc = m_pc + 4; m_ifinstr = m_buf_word; m_ifvalid = 1;
                m_hold = 0; m_pc = nxt;
            end
        end else if (ack) begin
            if (src) begin
                m_bubble(); m_pc = tgt; m_pend = 0;
            end else if (m_pend) begin
                if (fl || !st) m_bubble();
                m_pc = m_pend_tgt; m_pend = 0;
            end else if (fl) begin
                m_bubble(); m_pc = nxt;
            end else if (st) begin
                m_hold = 1; m_buf_word = word;
            end else begin
                m_ifpc = m_pc + 4; m_ifinstr = word; m_ifvalid = 1; m_pc = nxt;
            end
        end else begin
            if (src) begin m_pend = 1; m_pend_tgt = tgt; end
            if (src || fl || !st) m_bubble();
        end
    endtask

    task automatic do_reset();
        rst_i = 0;
        PCWrite_i = 0; IFIDStall_i = 0; IFFlush_i = 0; PCSrc_i = 0; BranchTarget_i = 0;
        imem.ack = 0; imem.data = 0;
        #1;
        check("rst_req",   imem.req, 0);
        check("rst_addr",  imem.addr, 32'h0);
        check("rst_ifpc",  IFID_PC_o, 0);
        check("rst_instr", IFID_Instr_o, 0);
        check("rst_valid", IFID_Valid_o, 0);
        check("rst_busy",  FetchBusy_o, 0);
        check("rst_scnt",  StallCnt_o, 0);
        check("rst_fcnt",  FlushCnt_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1;
        m_reset();
        mem_wait = 0;
    endtask

    task automatic step(input bit st, input bit pw, input bit src, input bit fl, input logic [31:0] tgt);
        bit ack;
        bit was_req;
        IFIDStall_i = st; PCWrite_i = pw; PCSrc_i = src; IFFlush_i = fl; BranchTarget_i = tgt;
        was_req = m_req();
        ack = was_req && (mem_wait >= mem_lat);
        imem.ack = ack;
        imem.data = ~m_pc;
        #1;
        check("req",  imem.req, was_req);
        check("addr", imem.addr, m_pc);
        check("busy", FetchBusy_o, was_req && !ack);
        last_busy = FetchBusy_o;
        model_step(ack, ~m_pc, st, pw, src, fl, tgt);
        @(posedge clk);
        #1;
        if (ack) begin
            mem_wait = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
        end else if (was_req) begin
            mem_wait++;
        end
        check("ifid_pc",    IFID_PC_o, m_ifpc);
        check("ifid_instr", IFID_Instr_o, m_ifinstr);
        check("ifid_valid", IFID_Valid_o, m_ifvalid);
`ifdef IF_FETCH_PERF_EN
        check("stall_cnt", StallCnt_o, m_stall_cnt);
        check("flush_cnt", FlushCnt_o, m_flush_cnt);
`else
        check("stall_cnt", StallCnt_o, 32'd0);
        check("flush_cnt", FlushCnt_o, 32'd0);
`endif
    endtask

    logic [31:0] sc0;

    initial begin
        rand_lat = 0;
        mem_lat  = 0;
        do_reset();
        step(0, 1, 0, 0, 0);

        // zero-wait memory: one instruction per cycle
        for (int i = 0; i < 3; i++) begin
            check("zw_addr", imem.addr, i * 4);
            step(0, 1, 0, 0, 0);
            check("zw_ifpc", IFID_PC_o, (i + 1) * 4);
            check("zw_valid", IFID_Valid_o, 1);
        end
        step(0, 1, 0, 0, 0);

        // three-cycle latency at 0x10
        check("lat_addr", imem.addr, 32'h10);
        mem_lat = 3;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            check("lat_busy", last_busy, 1);
            check("lat_bubble", IFID_Valid_o, 0);
        end
        step(0, 1, 0, 0, 0);
        check("lat_ifpc", IFID_PC_o, 32'h14);
        mem_lat = 0;

        // stall on return at 0x20 parks the word
        repeat (3) step(0, 1, 0, 0, 0);
        check("hold_addr", imem.addr, 32'h20);
        step(1, 0, 0, 0, 0);
        check("hold_req", imem.req, 0);
        check("hold_ifpc", IFID_PC_o, 32'h20);
        step(1, 0, 0, 0, 0);
        check("hold_frozen", IFID_PC_o, 32'h20);
        step(0, 1, 0, 0, 0);
        check("hold_ifpc2", IFID_PC_o, 32'h24);
        check("hold_next", imem.addr, 32'h24);

        // branch while 0x40 is outstanding
        repeat (7) step(0, 1, 0, 0, 0);
        check("br_addr", imem.addr, 32'h40);
        mem_lat = 2;
        step(0, 1, 1, 0, 32'h100);
        check("br_hold1", imem.addr, 32'h40);
        step(0, 1, 0, 0, 0);
        check("br_hold2", imem.addr, 32'h40);
        step(0, 1, 0, 0, 0);
        check("br_bubble", IFID_Valid_o, 0);
        check("br_target", imem.addr, 32'h100);
        mem_lat = 0;

        // branch beats stall
        step(0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 32'h100);
        check("flush_wins", IFID_Valid_o, 0);
        check("flush_addr", imem.addr, 32'h100);

        // PC wrap
        step(0, 1, 1, 0, 32'hFFFF_FFFC);
        check("wrap_addr", imem.addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0);
        check("wrap_ifpc", IFID_PC_o, 32'h0);
        check("wrap_next", imem.addr, 32'h0);
        sc0 = StallCnt_o;
        repeat (5) step(1, 0, 0, 0, 0);
`ifdef IF_FETCH_PERF_EN
        check("stall5", StallCnt_o - sc0, 32'd5);
`endif
        step(0, 1, 0, 0, 0);

        // randomized traffic with occasional mid-flight resets
        rand_lat = 1;
        mem_lat = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                     $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
                     {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch stage controller for the pipelined CPU: owns the PC, the instruction-memory request handshake and the IF/ID pipeline register, and obeys the PCWrite / IFIDStall / IFFlush / PCSrc controls produced by the hazard unit. It sits between the instruction memory and the ID stage. It tolerates multi-cycle memory latency and buffers a returned instruction while IF/ID is stalled.

## Interface
- PC_RESET, 32'h0000_0000, PC of the first fetch after reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- PCWrite_i  in  1  hazard unit: PC may advance
- IFIDStall_i  in  1  hazard unit: hold IF/ID contents
- IFFlush_i  in  1  hazard unit: load bubble into IF/ID
- PCSrc_i  in  1  branch taken; redirect to BranchTarget_i
- BranchTarget_i  in  32  redirect address
- imem_req_o  out  1  memory request, level, held until ack
- imem_addr_o  out  32  request address, stable while imem_req_o=1
- imem_ack_i  in  1  data valid this cycle; may coincide with first request cycle
- imem_data_i  in  32  instruction word
- IFID_PC_o  out  32  fetched PC + 4
- IFID_Instr_o  out  32  fetched instruction (NOP 32'h0 for bubble)
- IFID_Valid_o  out  1  IF/ID holds a real instruction
- FetchBusy_o  out  1  high in REQ without ack (memory wait)
- StallCnt_o  out  32  cycles with IFIDStall_i=1 (see Configuration)
- FlushCnt_o  out  32  count of PCSrc_i redirects (see Configuration)

## Operation
- States: IDLE (reset), REQ (request outstanding), HOLD (instruction buffered, IF/ID stalled).
- imem_req_o = (state==REQ); imem_addr_o = pc_q.
- IDLE -> REQ on first edge after reset release.
- REQ, ack, no squash, no stall: IF/ID <= {pc_q+4, imem_data_i, valid=1}; pc_q <= pc_q+4 if PCWrite_i; stay REQ.
- REQ, ack, IFIDStall_i=1: capture data into skid buffer -> HOLD; pc_q unchanged.
- REQ, no ack, IFIDStall_i=0: IF/ID <= bubble (valid=0, instr 0, PC 0).
- HOLD, IFIDStall_i=0: deliver buffer to IF/ID, pc_q <= pc_q+4 if PCWrite_i -> REQ.
- IFIDStall_i=1 in any state: IF/ID unchanged.
- Redirect (PCSrc_i=1, or IFFlush_i=1): IF/ID <= bubble; overrides IFIDStall_i.
  - REQ with ack same cycle: data discarded, pc_q <= BranchTarget_i, stay REQ.
  - REQ without ack: target latched in redir_q, squash_q set; pc_q/imem_addr_o unchanged until ack; on ack data discarded, pc_q <= redir_q, squash_q cleared, stay REQ.
  - Second redirect while squash_q set: redir_q overwritten (latest wins).
  - HOLD: buffer dropped, pc_q <= BranchTarget_i -> REQ.
  - IFFlush_i without PCSrc_i: bubble only, no redirect.
- PC arithmetic modulo 2^32; pc_q+4 wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset values: imem_req_o 0, imem_addr_o PC_RESET, IFID_PC_o 0, IFID_Instr_o 0, IFID_Valid_o 0, FetchBusy_o 0, counters 0.
- Zero-wait memory (ack in request cycle): one instruction per cycle; request at cycle n -> IF/ID valid from cycle n+1.
- Memory latency L cycles: L bubbles into IF/ID (unless stalled).
- Reset mid-request: request dropped immediately; squash_q, buffer cleared.
- HOLD -> REQ adds no bubble beyond the stall cycles.

## Configuration
- IF_FETCH_PERF_EN defined: StallCnt_o increments every cycle IFIDStall_i=1 and state!=IDLE; FlushCnt_o increments per PCSrc_i=1 cycle; both saturate at 32'hFFFF_FFFF.
- Undefined: counters absent, StallCnt_o and FlushCnt_o tied 0.

## Structure
- Shared package cpu_pipe_pkg: fetch state enum, NOP_INSTR = 32'h0, PC_STEP = 32'd4.
- One sub-module: if_skid_buf (single-entry PC/instruction buffer, load/clear/valid).

## Test plan
- Reset release, zero-wait memory returning addr as data -> imem_addr_o 0,4,8 on consecutive cycles; IFID_PC_o 4,8,12 with IFID_Valid_o=1.
- Ack delayed 3 cycles on addr 0x10 -> FetchBusy_o high 3 cycles, 3 bubbles, then IFID_PC_o=0x14.
- Ack at 0x20 while IFIDStall_i=1, PCWrite_i=0 for 2 cycles -> HOLD, IF/ID frozen, imem_req_o=0; stall drops -> IFID_PC_o=0x24, next addr 0x24.
- PCSrc_i=1, target 0x100 while REQ at 0x40 unacked -> imem_addr_o stays 0x40 until ack, data discarded, next addr 0x100, IF/ID bubble.
- PCSrc_i=1 and IFIDStall_i=1 same cycle -> flush wins, IFID_Valid_o=0, next fetch 0x100.
- pc_q=32'hFFFF_FFFC, ack -> next imem_addr_o 0, IFID_PC_o 0; with IF_FETCH_PERF_EN, 5 stall cycles -> StallCnt_o=5.
